// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter slice.
// Holds the pipeline stall-vector width and encodings (bit0 = PC/IF ... bit4 = WB,
// 1 = hold), the arbiter FSM state type and the default register/address widths.
package mem_port_arbiter_pkg;

   localparam int DEF_REG_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH = 32;

   localparam int STALL_WIDTH = 5;

   localparam logic [STALL_WIDTH-1:0] STALL_NOP    = 5'b00000;
   // Load-use hazard: hold PC and IF/ID, bubble into EX.
   localparam logic [STALL_WIDTH-1:0] STALL_LOAD   = 5'b00011;
   // Late branch resolution: hold PC through ID/EX, bubble into MEM.
   localparam logic [STALL_WIDTH-1:0] STALL_BRANCH = 5'b00111;
   // Fetch in flight: hold PC, bubble into ID.
   localparam logic [STALL_WIDTH-1:0] STALL_IMEM   = 5'b00001;
   // Data access in flight: hold PC..EX/MEM, bubble into WB.
   localparam logic [STALL_WIDTH-1:0] STALL_DMEM   = 5'b01111;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      IF_ADDR  = 3'd1,
      IF_DATA  = 3'd2,
      MEM_ADDR = 3'd3,
      MEM_DATA = 3'd4
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Saturating 8-bit wait counter used as the bus watchdog.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count at zero (state entry)
//   en       : count this cycle (arbiter is waiting on the bus)
//   expire   : count has reached LIMIT-1
module mem_port_arbiter_timeout_cnt #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [7:0] LAST_CNT = 8'(LIMIT - 1);

   logic [7:0] cnt_r;

   // Wait counter: clear has priority over counting; holds at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= 8'd0;
      end else if (clr) begin
         cnt_r <= 8'd0;
      end else if (en && (cnt_r != 8'hFF)) begin
         cnt_r <= cnt_r + 8'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the unified memory bus between instruction fetch and the
// MEM-stage data port. One outstanding req/gnt/rvalid transaction at a time,
// data requests win ties, watchdog abort on a stuck bus, and the arbiter's own
// wait-state stall is OR-merged with the hazard stall from stall_unit.
// Ports:
//   if_*      : fetch requester (req held until if_valid)
//   mem_*     : data requester (req held until mem_valid)
//   bus_*     : shared bus command/response
//   stall_in  : hazard stall vector, stall : merged stall vector
//   bus_err   : one-cycle pulse when the watchdog aborts a transaction
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_REG_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_req,
   input  logic [ADDR_WIDTH-1:0]     if_addr,
   output logic [DATA_WIDTH-1:0]     if_rdata,
   output logic                      if_valid,
   input  logic                      mem_req,
   input  logic                      mem_we,
   input  logic [ADDR_WIDTH-1:0]     mem_addr,
   input  logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH/8-1:0]   mem_be,
   output logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      mem_valid,
   output logic                      bus_req,
   output logic                      bus_we,
   output logic [ADDR_WIDTH-1:0]     bus_addr,
   output logic [DATA_WIDTH-1:0]     bus_wdata,
   output logic [DATA_WIDTH/8-1:0]   bus_be,
   input  logic                      bus_gnt,
   input  logic                      bus_rvalid,
   input  logic [DATA_WIDTH-1:0]     bus_rdata,
   input  logic [STALL_WIDTH-1:0]    stall_in,
   output logic [STALL_WIDTH-1:0]    stall,
   output logic                      bus_err
);

   arb_state_t             state_r;
   arb_state_t             state_nxt_s;
   logic                   addr_ph_s;
   logic                   data_ph_s;
   logic                   expire_s;
   logic                   req_s;
   logic                   gnt_ok_s;
   logic                   if_done_s;
   logic                   mem_done_s;
   logic                   timeout_s;
   logic                   clr_s;
   logic [STALL_WIDTH-1:0] arb_stall_s;

   // Phase decode and handshake qualification. bus_req depends only on the
   // registered state and counter, so there is no gnt -> req path; on the
   // expiring cycle the request is withdrawn and any gnt is not honoured.
   always_comb begin
      addr_ph_s  = (state_r == IF_ADDR) || (state_r == MEM_ADDR);
      data_ph_s  = (state_r == IF_DATA) || (state_r == MEM_DATA);
      req_s      = addr_ph_s && !expire_s && !rst;
      gnt_ok_s   = req_s && bus_gnt;
      if_done_s  = (state_r == IF_DATA)  && bus_rvalid && !rst;
      mem_done_s = (state_r == MEM_DATA) && bus_rvalid && !rst;
      timeout_s  = expire_s && !rst && !gnt_ok_s &&
                   (addr_ph_s || (data_ph_s && !bus_rvalid));
   end

   // Next-state selection; mem_req wins a tie in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (mem_req) begin
               state_nxt_s = MEM_ADDR;
            end else if (if_req) begin
               state_nxt_s = IF_ADDR;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         IF_ADDR, MEM_ADDR: begin
            if (gnt_ok_s) begin
               state_nxt_s = (state_r == IF_ADDR) ? IF_DATA : MEM_DATA;
            end else if (timeout_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         IF_DATA, MEM_DATA: begin
            if (bus_rvalid || timeout_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Arbiter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Watchdog restarts on every state change and runs while on the bus.
   assign clr_s = (state_nxt_s != state_r);

   mem_port_arbiter_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_arb_timeout_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_s),
      .en     (addr_ph_s || data_ph_s),
      .expire (expire_s)
   );

   // Bus command follows the requester owning the address phase.
   always_comb begin
      case (state_r)
         IF_ADDR: begin
            bus_we    = 1'b0;
            bus_addr  = if_addr;
            bus_wdata = {DATA_WIDTH{1'b0}};
            bus_be    = {(DATA_WIDTH/8){1'b1}};
         end
         MEM_ADDR: begin
            bus_we    = mem_we;
            bus_addr  = mem_addr;
            bus_wdata = mem_wdata;
            bus_be    = mem_be;
         end
         default: begin
            bus_we    = 1'b0;
            bus_addr  = {ADDR_WIDTH{1'b0}};
            bus_wdata = {DATA_WIDTH{1'b0}};
            bus_be    = {(DATA_WIDTH/8){1'b0}};
         end
      endcase
   end

   // Arbiter stall: a pending data access dominates a pending fetch, and the
   // stall releases in the completion cycle itself.
   always_comb begin
      if (mem_req && !mem_done_s) begin
         arb_stall_s = STALL_DMEM;
      end else if (if_req && !if_done_s) begin
         arb_stall_s = STALL_IMEM;
      end else begin
         arb_stall_s = STALL_NOP;
      end
   end

   assign stall     = rst ? STALL_NOP : (stall_in | arb_stall_s);
   assign bus_req   = req_s;
   assign bus_err   = timeout_s;
   assign if_valid  = if_done_s;
   assign mem_valid = mem_done_s;
   assign if_rdata  = if_done_s  ? bus_rdata : {DATA_WIDTH{1'b0}};
   assign mem_rdata = mem_done_s ? bus_rdata : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// responses into queues, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic [4:0]  stall_in;
   logic [4:0]  stall;
   logic        bus_err;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .stall_in(stall_in), .stall(stall), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; logic [4:0] stall; logic breq; } chk_t;
   typedef struct { int cyc; logic is_store; logic [31:0] data; } rsp_t;
   typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } cmd_t;

   chk_t chk_q[$];
   rsp_t if_q[$];
   rsp_t mem_q[$];
   cmd_t cmd_q[$];
   int   err_q[$];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_cyc(input logic [4:0] s, input logic r);
      chk_q.push_back('{cyc, s, r});
   endtask

   task automatic exp_cmd(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
      cmd_q.push_back('{a, w, b, d});
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = 32'h0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_be = 4'h0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; stall_in = 5'b00000;
   endtask

   // Monitor: compare DUT outputs against the queued expectations.
   initial forever begin
      chk_t c;
      rsp_t r;
      cmd_t m;
      int   e;
      @(negedge clk);
      if (chk_q.size() > 0 && chk_q[0].cyc == cyc) begin
         c = chk_q.pop_front();
         checks++;
         if (stall !== c.stall) begin
            errors++;
            $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, c.stall);
         end
         checks++;
         if (bus_req !== c.breq) begin
            errors++;
            $display("FAIL bus_req cyc=%0d got=%b exp=%b", cyc, bus_req, c.breq);
         end
      end
      if (if_valid !== 1'b0) begin
         checks++;
         if (if_q.size() == 0) begin
            errors++;
            $display("FAIL if_valid_unexpected cyc=%0d got=%b exp=0", cyc, if_valid);
         end else begin
            r = if_q.pop_front();
            if (r.cyc != cyc || if_rdata !== r.data) begin
               errors++;
               $display("FAIL if_rsp cyc=%0d data=%h exp_cyc=%0d exp_data=%h", cyc, if_rdata, r.cyc, r.data);
            end
         end
      end
      if (mem_valid !== 1'b0) begin
         checks++;
         if (mem_q.size() == 0) begin
            errors++;
            $display("FAIL mem_valid_unexpected cyc=%0d got=%b exp=0", cyc, mem_valid);
         end else begin
            r = mem_q.pop_front();
            if (r.cyc != cyc || (!r.is_store && mem_rdata !== r.data)) begin
               errors++;
               $display("FAIL mem_rsp cyc=%0d data=%h exp_cyc=%0d exp_data=%h", cyc, mem_rdata, r.cyc, r.data);
            end
         end
      end
      if (bus_err !== 1'b0) begin
         checks++;
         if (err_q.size() == 0) begin
            errors++;
            $display("FAIL bus_err_unexpected cyc=%0d got=%b exp=0", cyc, bus_err);
         end else begin
            e = err_q.pop_front();
            if (e != cyc) begin
               errors++;
               $display("FAIL bus_err_cycle got=%0d exp=%0d", cyc, e);
            end
         end
      end
      if (bus_req === 1'b1 && bus_gnt === 1'b1) begin
         checks++;
         if (cmd_q.size() == 0) begin
            errors++;
            $display("FAIL bus_cmd_unexpected cyc=%0d addr=%h", cyc, bus_addr);
         end else begin
            m = cmd_q.pop_front();
            if (bus_addr !== m.addr || bus_we !== m.we || bus_be !== m.be || bus_wdata !== m.wdata) begin
               errors++;
               $display("FAIL bus_cmd cyc=%0d got a=%h we=%b be=%b d=%h exp a=%h we=%b be=%b d=%h",
                        cyc, bus_addr, bus_we, bus_be, bus_wdata, m.addr, m.we, m.be, m.wdata);
            end
         end
      end
   end

   initial begin
      idle_inputs();
      rst = 1'b1;

      // Reset: stall forced to zero even with hazard and requests present.
      stall_in = 5'b11111; if_req = 1'b1; mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_cyc(5'b00000, 1'b0);
      end
      tick();
      rst = 1'b0; idle_inputs();
      exp_cyc(5'b00000, 1'b0);
      tick();

      // Fetch only.
      if_req = 1'b1; if_addr = 32'h100;
      exp_cyc(5'b00001, 1'b0);
      tick(); bus_gnt = 1'b1; exp_cyc(5'b00001, 1'b1);
      exp_cmd(32'h100, 1'b0, 4'hF, 32'h0);
      tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h00500093;
      exp_cyc(5'b00000, 1'b0);
      if_q.push_back('{cyc, 1'b0, 32'h00500093});
      tick(); idle_inputs(); exp_cyc(5'b00000, 1'b0);
      tick();

      // Simultaneous fetch and load: load first, fetch starts after mem_valid.
      if_req = 1'b1; if_addr = 32'h104;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_be = 4'hF; mem_wdata = 32'h0BAD0BAD;
      exp_cyc(5'b01111, 1'b0);
      tick(); bus_gnt = 1'b1; exp_cyc(5'b01111, 1'b1);
      exp_cmd(32'h2000, 1'b0, 4'hF, 32'h0BAD0BAD);
      tick(); bus_gnt = 1'b0; exp_cyc(5'b01111, 1'b0);
      tick(); bus_rvalid = 1'b1; bus_rdata = 32'h11223344; exp_cyc(5'b00001, 1'b0);
      mem_q.push_back('{cyc, 1'b0, 32'h11223344});
      tick(); mem_req = 1'b0; bus_rvalid = 1'b0; exp_cyc(5'b00001, 1'b0);
      tick(); bus_gnt = 1'b1; exp_cyc(5'b00001, 1'b1);
      exp_cmd(32'h104, 1'b0, 4'hF, 32'h0);
      tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hA5A5A5A5;
      exp_cyc(5'b00000, 1'b0);
      if_q.push_back('{cyc, 1'b0, 32'hA5A5A5A5});
      tick(); idle_inputs(); exp_cyc(5'b00000, 1'b0);
      tick();

      // Store raised during IF_DATA waits for the fetch to finish.
      if_req = 1'b1; if_addr = 32'h200;
      exp_cyc(5'b00001, 1'b0);
      tick(); bus_gnt = 1'b1; exp_cyc(5'b00001, 1'b1);
      exp_cmd(32'h200, 1'b0, 4'hF, 32'h0);
      tick(); bus_gnt = 1'b0;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3000; mem_wdata = 32'hCAFEF00D; mem_be = 4'b0011;
      exp_cyc(5'b01111, 1'b0);
      tick(); bus_rvalid = 1'b1; bus_rdata = 32'h00000013; exp_cyc(5'b01111, 1'b0);
      if_q.push_back('{cyc, 1'b0, 32'h00000013});
      tick(); if_req = 1'b0; bus_rvalid = 1'b0; exp_cyc(5'b01111, 1'b0);
      tick(); bus_gnt = 1'b1; exp_cyc(5'b01111, 1'b1);
      exp_cmd(32'h3000, 1'b1, 4'b0011, 32'hCAFEF00D);
      tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
      exp_cyc(5'b00000, 1'b0);
      mem_q.push_back('{cyc, 1'b1, 32'h0});
      tick(); idle_inputs(); exp_cyc(5'b00000, 1'b0);
      tick();

      // Timeout: gnt withheld, abort in the 4th wait cycle, then retry.
      if_req = 1'b1; if_addr = 32'h400;
      exp_cyc(5'b00001, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); exp_cyc(5'b00001, 1'b1);
      end
      tick(); exp_cyc(5'b00001, 1'b0);
      err_q.push_back(cyc);
      tick(); exp_cyc(5'b00001, 1'b0);
      tick(); bus_gnt = 1'b1; exp_cyc(5'b00001, 1'b1);
      exp_cmd(32'h400, 1'b0, 4'hF, 32'h0);
      tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
      exp_cyc(5'b00000, 1'b0);
      if_q.push_back('{cyc, 1'b0, 32'h12345678});
      tick(); idle_inputs(); exp_cyc(5'b00000, 1'b0);
      tick();

      // Reset in MEM_DATA, then late rvalid is ignored.
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000; mem_be = 4'hF;
      exp_cyc(5'b01111, 1'b0);
      tick(); bus_gnt = 1'b1; exp_cyc(5'b01111, 1'b1);
      exp_cmd(32'h5000, 1'b0, 4'hF, 32'h0);
      tick(); bus_gnt = 1'b0; rst = 1'b1; stall_in = 5'b00011; exp_cyc(5'b00000, 1'b0);
      tick(); mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF; exp_cyc(5'b00000, 1'b0);
      tick(); rst = 1'b0; stall_in = 5'b00000; exp_cyc(5'b00000, 1'b0);
      tick(); idle_inputs(); bus_gnt = 1'b1; exp_cyc(5'b00000, 1'b0);
      tick(); idle_inputs();

      // Merge: hazard stall passes through unchanged with no memory activity.
      stall_in = STALL_LOAD; exp_cyc(STALL_LOAD, 1'b0);
      tick(); stall_in = STALL_BRANCH; exp_cyc(STALL_BRANCH, 1'b0);
      tick(); stall_in = 5'b10100; exp_cyc(5'b10100, 1'b0);
      tick(); idle_inputs();
      tick(); tick();

      // Every queued expectation must have been consumed.
      checks++;
      if (if_q.size() != 0) begin
         errors++;
         $display("FAIL if_q_leftover got=%0d exp=0", if_q.size());
      end
      checks++;
      if (mem_q.size() != 0) begin
         errors++;
         $display("FAIL mem_q_leftover got=%0d exp=0", mem_q.size());
      end
      checks++;
      if (cmd_q.size() != 0) begin
         errors++;
         $display("FAIL cmd_q_leftover got=%0d exp=0", cmd_q.size());
      end
      checks++;
      if (err_q.size() != 0) begin
         errors++;
         $display("FAIL err_q_leftover got=%0d exp=0", err_q.size());
      end
      checks++;
      if (chk_q.size() != 0) begin
         errors++;
         $display("FAIL chk_q_leftover got=%0d exp=0", chk_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
